uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 bytes.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 4: number of cycles to wait for i_tx_busy to rise after a launch.
REQ-003 The block SHALL have port i_clock  in  1  the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port i_reset  in  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_data  in  8  byte to enqueue.
REQ-006 The block SHALL have port i_write  in  1  enqueue strobe, sampled every cycle.
REQ-007 The block SHALL have port o_full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-008 The block SHALL have port o_empty  out  1  FIFO holds 0 bytes.
REQ-009 The block SHALL have port o_count  out  DEPTH_LOG2+1  current occupancy.
REQ-010 The block SHALL have port o_tx_data  out  8  byte presented to uart_tx.
REQ-011 The block SHALL have port o_tx_act  out  1  one-cycle launch pulse to uart_tx.
REQ-012 The block SHALL have port i_tx_busy  in  1  busy flag from uart_tx.
REQ-013 The block SHALL have port o_overflow  out  1  sticky overflow flag (see Configuration).

Function
REQ-014 The FIFO SHALL be a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo depth, plus a DEPTH_LOG2+1-bit count.
REQ-015 An i_write sampled while o_full=0 SHALL store i_data at the write pointer and advance it; an i_write while o_full=1 SHALL be dropped, even if a pop occurs in the same cycle.
REQ-016 A simultaneous accepted write and pop SHALL leave o_count unchanged; o_full, o_empty and o_count SHALL be registered and consistent with each other every cycle.
REQ-017 The launch FSM SHALL have the states IDLE, LAUNCH, WAIT_HI and WAIT_LO.
REQ-018 IDLE->LAUNCH SHALL occur when o_empty=0 and i_tx_busy=0.
REQ-019 In LAUNCH, the FSM SHALL hold o_tx_act=1 for exactly one cycle, drive o_tx_data with the head byte, and pop the head; the FSM then SHALL go to WAIT_HI.
REQ-020 WAIT_HI->WAIT_LO SHALL occur when i_tx_busy=1; if i_tx_busy stays 0 for ACK_TIMEOUT cycles, the FSM SHALL return to IDLE.
REQ-021 WAIT_LO->IDLE SHALL occur when i_tx_busy=0.
REQ-022 o_tx_data SHALL hold the last launched byte until the next LAUNCH.
REQ-023 Latency: for a write accepted at edge k into an empty FIFO with the FSM in IDLE and busy low, o_count SHALL be 1 after edge k and o_tx_act SHALL be high in the cycle after edge k+1.
REQ-024 Back-to-back launches SHALL be separated by at least one full busy-high/busy-low cycle; o_tx_act SHALL never be asserted while i_tx_busy=1.
REQ-025 Bytes SHALL be launched in strict write order, with no loss or duplication, across pointer wrap-around.

Reset
REQ-026 While i_reset=1 at an edge, the block SHALL clear pointers and count and set the FSM to IDLE.
REQ-027 Reset values SHALL be: o_tx_act=0, o_tx_data=8'h00, o_empty=1, o_full=0, o_count=0, o_overflow=0.
REQ-028 Reset asserted mid-transfer SHALL discard all queued bytes; after release the FSM SHALL wait in IDLE for new writes.
REQ-029 Memory contents need not be cleared on reset.

Configuration
REQ-030 The macro UART_TX_FIFO_OVERFLOW_EN SHALL control the overflow flag.
REQ-031 When UART_TX_FIFO_OVERFLOW_EN is defined, o_overflow SHALL set on any dropped write and stay set until reset.
REQ-032 When UART_TX_FIFO_OVERFLOW_EN is undefined, o_overflow SHALL be tied to 0 and no overflow logic SHALL be built.

Verification
REQ-033 Reset, then write 8'h48 with busy model idle -> o_tx_act pulses once, 2 cycles after the write edge, with o_tx_data=8'h48; o_empty returns to 1.
REQ-034 Burst-write "Hello" (5 bytes) with the uart_tx model busy for 10 cycles per byte -> 5 act pulses in order 48,65,6C,6C,6F; no pulse while busy=1.
REQ-035 DEPTH_LOG2=2: write 6 bytes back-to-back with busy held high -> o_full after 4 writes, bytes 5-6 dropped, o_overflow=1 (macro defined) or 0 (undefined).
REQ-036 Write 20 bytes over time with DEPTH_LOG2=2 and a random-latency busy model -> all 20 bytes launched in order, covering pointer wrap.
REQ-037 Busy model never responds -> FSM returns to IDLE after ACK_TIMEOUT=4 cycles and launches the next byte.
REQ-038 Assert i_reset during WAIT_LO with 3 bytes queued -> o_count=0, o_empty=1, and no further act pulse until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_tx: queues written bytes and launches them one at a
// time, pacing on the transmitter's busy flag. Optional UART_TX_FIFO_OVERFLOW_EN
// builds a sticky flag for writes dropped while full.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [7:0]            i_data,
  input  logic                  i_write,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_act,
  input  logic                  i_tx_busy,
  output logic                  o_overflow,
  output logic [1:0]            o_state
);

  // Handshakes: a write is taken on any edge where i_write=1 and o_full=0
  // (otherwise dropped); o_tx_act is a one-cycle launch that the transmitter
  // acknowledges by raising i_tx_busy, and the next launch waits for it to fall.
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LAUNCH  = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  localparam logic [DEPTH_LOG2:0] FULL_COUNT   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [TW-1:0]       TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_n;
  logic                  full;
  logic                  empty;
  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [TW-1:0]         timer;
  logic [7:0]            tx_data;
  logic                  push;
  logic                  pop;

  assign push = i_write && !full;
  assign pop  = (state == LAUNCH);

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // Flags are registered from the next count so all three always agree.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == FULL_COUNT);
      empty <= (count_n == '0);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!empty && !i_tx_busy) state_n = LAUNCH;
      LAUNCH:  state_n = WAIT_HI;
      WAIT_HI: begin
        if (i_tx_busy)                   state_n = WAIT_LO;
        else if (timer == TIMEOUT_LAST)  state_n = IDLE;
      end
      WAIT_LO: if (!i_tx_busy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The head byte is captured on entry to LAUNCH and held until the next one.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= IDLE;
      timer   <= '0;
      tx_data <= 8'h00;
    end else begin
      state <= state_n;
      if (state == WAIT_HI) timer <= timer + 1'b1;
      else                  timer <= '0;
      if (state == IDLE && state_n == LAUNCH) tx_data <= mem[rd_ptr];
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow;
  always_ff @(posedge i_clock) begin
    if (i_reset)                overflow <= 1'b0;
    else if (i_write && full)   overflow <= 1'b1;
  end
  assign o_overflow = overflow;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_full    = full;
  assign o_empty   = empty;
  assign o_count   = count;
  assign o_tx_data = tx_data;
  assign o_tx_act  = (state == LAUNCH);
  assign o_state   = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH_LOG2=2, ACK_TIMEOUT=4) with a
// behavioural uart_tx busy model and an in-order launch scoreboard.
module tb_uart_tx_fifo;

  localparam int DL = 2;
  localparam int AT = 4;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  localparam int M_NORMAL = 0;
  localparam int M_RAND   = 1;
  localparam int M_NONE   = 2;
  localparam int M_HOLD   = 3;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic [7:0]    i_data;
  logic          i_write;
  logic          o_full;
  logic          o_empty;
  logic [DL:0]   o_count;
  logic [7:0]    o_tx_data;
  logic          o_tx_act;
  logic          i_tx_busy;
  logic          o_overflow;
  logic [1:0]    o_state;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  int busy_mode = M_NORMAL;
  int busy_len  = 3;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.DEPTH_LOG2(DL), .ACK_TIMEOUT(AT)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .i_write    (i_write),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_tx_data  (o_tx_data),
    .o_tx_act   (o_tx_act),
    .i_tx_busy  (i_tx_busy),
    .o_overflow (o_overflow),
    .o_state    (o_state)
  );

  // Clock / reset block
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wr(input logic [7:0] b);
    i_data  = b;
    i_write = 1'b1;
    @(negedge i_clock);
    i_write = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int k = 0;
    while (n_pulse < target && k < budget) begin
      @(negedge i_clock);
      k++;
    end
    check(tag, n_pulse, target);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int k = 0;
    while (o_state !== s && k < budget) begin
      @(negedge i_clock);
      k++;
    end
    check(tag, o_state, s);
  endtask

  // uart_tx model: after a launch, busy rises 1..3 cycles later for a while
  initial begin
    int lat;
    int len;
    i_tx_busy = 1'b0;
    forever begin
      @(negedge i_clock);
      if (busy_mode == M_HOLD) begin
        i_tx_busy = 1'b1;
      end else begin
        i_tx_busy = 1'b0;
        if (o_tx_act === 1'b1 && busy_mode != M_NONE) begin
          lat = (busy_mode == M_RAND) ? $urandom_range(1, 3) : 1;
          len = (busy_mode == M_RAND) ? $urandom_range(1, 12) : busy_len;
          repeat (lat) @(negedge i_clock);
          i_tx_busy = 1'b1;
          repeat (len) @(negedge i_clock);
          i_tx_busy = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every launch must carry the oldest accepted byte, never under busy
  always @(posedge i_clock) begin
    #2;
    if (o_tx_act === 1'b1) begin
      n_pulse++;
      check("act_while_busy", i_tx_busy, 1'b0);
      if (exp_q.size() == 0) check("unexpected_act", 1, 0);
      else check("launch_byte", o_tx_data, exp_q.pop_front());
    end
  end

  initial begin
    i_reset = 1'b1;
    i_data  = 8'h00;
    i_write = 1'b0;
    repeat (3) @(negedge i_clock);
    check("rst_act",   o_tx_act, 1'b0);
    check("rst_data",  o_tx_data, 8'h00);
    check("rst_empty", o_empty, 1'b1);
    check("rst_full",  o_full, 1'b0);
    check("rst_count", o_count, 0);
    check("rst_ovf",   o_overflow, 1'b0);
    check("rst_state", o_state, S_IDLE);
    i_reset = 1'b0;
    @(negedge i_clock);

    // Single byte: count 1 after write edge, launch in the cycle after the next edge
    exp_q.push_back(8'h48);
    wr(8'h48);
    check("t1_count", o_count, 1);
    check("t1_empty", o_empty, 1'b0);
    check("t1_act_early", o_tx_act, 1'b0);
    @(negedge i_clock);
    check("t1_act", o_tx_act, 1'b1);
    check("t1_data", o_tx_data, 8'h48);
    @(negedge i_clock);
    check("t1_act_once", o_tx_act, 1'b0);
    check("t1_empty_back", o_empty, 1'b1);
    wait_state(S_IDLE, 20, "t1_idle");
    check("t1_pulses", n_pulse, 1);
    check("t1_data_hold", o_tx_data, 8'h48);

    // "Hello" burst, busy 10 cycles per byte
    busy_len = 10;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h48); exp_q.push_back(8'h65); exp_q.push_back(8'h6C);
    exp_q.push_back(8'h6C); exp_q.push_back(8'h6F);
    wr(8'h48); wr(8'h65); wr(8'h6C); wr(8'h6C); wr(8'h6F);
    check("t2_count_peak", o_count, 4);
    wait_pulses(6, 200, "t2_pulses");
    wait_state(S_IDLE, 40, "t2_idle");
    check("t2_drained", exp_q.size(), 0);
    check("t2_empty", o_empty, 1'b1);

    // Fill with busy held high: full after 4, writes 5-6 dropped
    busy_mode = M_HOLD;
    repeat (2) @(negedge i_clock);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(8'hA0 + 8'(i));
      wr(8'hA0 + 8'(i));
      check("t3_count", o_count, (i < 4) ? i + 1 : 4);
      check("t3_full", o_full, (i >= 3) ? 1'b1 : 1'b0);
    end
    check("t3_state_idle", o_state, S_IDLE);
    check("t3_ovf", o_overflow, EXP_OVF);
    busy_mode = M_NORMAL;
    busy_len  = 2;
    wait_pulses(10, 200, "t3_pulses");
    wait_state(S_IDLE, 40, "t3_idle");
    check("t3_drained", exp_q.size(), 0);
    check("t3_ovf_sticky", o_overflow, EXP_OVF);
    check("t3_not_full", o_full, 1'b0);

    // 20 bytes with random gaps and random busy latency, across pointer wrap
    busy_mode = M_RAND;
    for (int i = 0; i < 20; i++) begin
      int g = 0;
      while (o_full === 1'b1 && g < 200) begin
        @(negedge i_clock);
        g++;
      end
      repeat ($urandom_range(0, 3)) @(negedge i_clock);
      exp_q.push_back(8'h10 + 8'(i * 7));
      wr(8'h10 + 8'(i * 7));
    end
    wait_pulses(30, 1500, "t4_pulses");
    wait_state(S_IDLE, 40, "t4_idle");
    check("t4_drained", exp_q.size(), 0);

    // Transmitter never acknowledges: timeout after 4 cycles in WAIT_HI
    busy_mode = M_NONE;
    repeat (2) @(negedge i_clock);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    wr(8'h11);
    wr(8'h22);
    check("t5_act1", o_tx_act, 1'b1);
    check("t5_data1", o_tx_data, 8'h11);
    for (int i = 0; i < AT; i++) begin
      @(negedge i_clock);
      check("t5_wait_hi", o_state, S_WAIT_HI);
    end
    @(negedge i_clock);
    check("t5_timeout_idle", o_state, S_IDLE);
    @(negedge i_clock);
    check("t5_act2", o_tx_act, 1'b1);
    check("t5_data2", o_tx_data, 8'h22);
    wait_state(S_IDLE, 20, "t5_idle");
    check("t5_pulses", n_pulse, 32);

    // Reset during WAIT_LO with 3 bytes queued
    busy_mode = M_NORMAL;
    busy_len  = 20;
    repeat (2) @(negedge i_clock);
    exp_q.push_back(8'hC0);
    wr(8'hC0); wr(8'hC1); wr(8'hC2); wr(8'hC3);
    check("t6_wait_lo", o_state, S_WAIT_LO);
    check("t6_queued", o_count, 3);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    check("t6_count", o_count, 0);
    check("t6_empty", o_empty, 1'b1);
    check("t6_state", o_state, S_IDLE);
    check("t6_data", o_tx_data, 8'h00);
    check("t6_ovf", o_overflow, 1'b0);
    repeat (30) @(negedge i_clock);
    check("t6_no_act", n_pulse, 33);
    exp_q.push_back(8'h5A);
    wr(8'h5A);
    wait_pulses(34, 20, "t6_new_pulse");
    wait_state(S_IDLE, 40, "t6_idle");
    check("t6_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
